// File: rtl/framebuf_window_if.sv
// Capture-side write stream, display-side read stream and buffer status for framebuf_window.
interface framebuf_window_if #(
  parameter int unsigned PIXEL_W = 36
);
  logic               wr_valid;
  logic               wr_sof;
  logic [PIXEL_W-1:0] wr_pixel;
  logic               rd_valid;
  logic               rd_sof;
  logic [PIXEL_W-1:0] rd_pixel;
  logic               rd_done;
  logic               wr_bank;
  logic               rd_bank;
  logic               frame_ready;
  logic [7:0]         drop_count;

  modport master (
    output wr_valid, wr_sof, wr_pixel, rd_valid, rd_sof,
    input  rd_pixel, rd_done, wr_bank, rd_bank, frame_ready, drop_count
  );

  modport slave (
    input  wr_valid, wr_sof, wr_pixel, rd_valid, rd_sof,
    output rd_pixel, rd_done, wr_bank, rd_bank, frame_ready, drop_count
  );
endinterface

// File: rtl/framebuf_window.sv
// Windowed frame buffer: stores a rectangle of the source frame in block RAM and replays it
// in display raster order, with optional two-bank handoff so the display never sees a torn frame.
module framebuf_window #(
  parameter int unsigned       SRC_W      = 640,
  parameter int unsigned       SRC_H      = 480,
  parameter int unsigned       WIN_X0     = 0,
  parameter int unsigned       WIN_Y0     = 0,
  parameter int unsigned       WIN_W      = 128,
  parameter int unsigned       WIN_H      = 128,
  parameter int unsigned       PIXEL_W    = 36,
  parameter logic [PIXEL_W-1:0] BG_PIXEL  = '0,
  parameter int unsigned       DOUBLE_BUF = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  framebuf_window_if.slave bus
);
  localparam int unsigned NBANK      = (DOUBLE_BUF != 0) ? 2 : 1;
  localparam int unsigned BANK_WORDS = WIN_W * WIN_H;
  localparam int unsigned DEPTH      = NBANK * BANK_WORDS;
  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned XW         = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int unsigned YW         = (SRC_H > 1) ? $clog2(SRC_H) : 1;

  typedef enum logic [0:0] {ST_WRITE, ST_HOLD} wr_state_t;
  typedef enum logic [1:0] {SEL_ZERO, SEL_BG, SEL_RAM} rd_sel_t;

  function automatic logic [XW-1:0] next_x(input logic [XW-1:0] x);
    return (32'(x) == SRC_W - 1) ? '0 : x + XW'(1);
  endfunction

  function automatic logic [YW-1:0] next_y(input logic [XW-1:0] x, input logic [YW-1:0] y);
    if (32'(x) != SRC_W - 1) return y;
    return (32'(y) == SRC_H - 1) ? '0 : y + YW'(1);
  endfunction

  // Window offsets wrap below the origin, so a single unsigned compare covers both edges.
  function automatic logic [AW-1:0] addr_of(input logic bank, input logic [31:0] dx,
                                            input logic [31:0] dy);
    logic [31:0] a;
    a = (bank ? BANK_WORDS : 32'd0) + dy * WIN_W + dx;
    return a[AW-1:0];
  endfunction

  logic [PIXEL_W-1:0] mem [DEPTH];
  logic [PIXEL_W-1:0] ram_q_reg;

  logic [XW-1:0]      wx_reg, rx_reg;
  logic [YW-1:0]      wy_reg, ry_reg;
  wr_state_t          state_reg;
  logic               frame_ready_reg;
  logic [7:0]         drop_count_reg;
  logic               wr_bank_reg, rd_bank_reg;
  logic               wen_reg;
  logic [AW-1:0]      waddr_reg;
  logic [PIXEL_W-1:0] wdata_reg;
  logic               rvalid1_reg, rin1_reg;
  logic [AW-1:0]      raddr_reg;
  logic               rd_done_reg;
  rd_sel_t            rsel_reg;

  logic [XW-1:0]      wpx, rpx;
  logic [YW-1:0]      wpy, rpy;
  logic [31:0]        wdx, wdy, rdx, rdy;
  logic               w_in, r_in, w_last, w_accept, w_store, w_complete, swap, rd_bank_eff;
  logic [PIXEL_W-1:0] rd_pixel_next;

  always_comb begin
    wpx         = bus.wr_sof ? '0 : wx_reg;
    wpy         = bus.wr_sof ? '0 : wy_reg;
    rpx         = bus.rd_sof ? '0 : rx_reg;
    rpy         = bus.rd_sof ? '0 : ry_reg;
    wdx         = 32'(wpx) - WIN_X0;
    wdy         = 32'(wpy) - WIN_Y0;
    rdx         = 32'(rpx) - WIN_X0;
    rdy         = 32'(rpy) - WIN_Y0;
    w_in        = (wdx < WIN_W) && (wdy < WIN_H);
    r_in        = (rdx < WIN_W) && (rdy < WIN_H);
    w_last      = (32'(wpx) == SRC_W - 1) && (32'(wpy) == SRC_H - 1);
    // A start-of-frame in HOLD re-enters WRITE only if the reader has taken the last frame.
    w_accept    = (state_reg == ST_WRITE) || (bus.wr_sof && !frame_ready_reg);
    w_store     = bus.wr_valid && w_accept && w_in;
    w_complete  = (DOUBLE_BUF != 0) && bus.wr_valid && w_accept && w_last;
    swap        = (DOUBLE_BUF != 0) && bus.rd_sof && frame_ready_reg;
    rd_bank_eff = swap ? wr_bank_reg : rd_bank_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wx_reg          <= '0;
      wy_reg          <= '0;
      rx_reg          <= '0;
      ry_reg          <= '0;
      state_reg       <= ST_WRITE;
      frame_ready_reg <= 1'b0;
      drop_count_reg  <= '0;
      wr_bank_reg     <= 1'b0;
      rd_bank_reg     <= (DOUBLE_BUF != 0);
      wen_reg         <= 1'b0;
      waddr_reg       <= '0;
      wdata_reg       <= '0;
      rvalid1_reg     <= 1'b0;
      rin1_reg        <= 1'b0;
      raddr_reg       <= '0;
      rd_done_reg     <= 1'b0;
      rsel_reg        <= SEL_ZERO;
    end else begin
      if (bus.wr_valid) begin
        wx_reg <= next_x(wpx);
        wy_reg <= next_y(wpx, wpy);
      end else begin
        wx_reg <= wpx;
        wy_reg <= wpy;
      end
      if (bus.rd_valid) begin
        rx_reg <= next_x(rpx);
        ry_reg <= next_y(rpx, rpy);
      end else begin
        rx_reg <= rpx;
        ry_reg <= rpy;
      end

      if (w_complete)    state_reg <= ST_HOLD;
      else if (w_accept) state_reg <= ST_WRITE;

      if ((DOUBLE_BUF != 0) && state_reg == ST_HOLD && bus.wr_sof && frame_ready_reg &&
          drop_count_reg != 8'hFF)
        drop_count_reg <= drop_count_reg + 8'd1;

      if (w_complete)    frame_ready_reg <= 1'b1;
      else if (swap)     frame_ready_reg <= 1'b0;
      if (swap) begin
        rd_bank_reg <= wr_bank_reg;
        wr_bank_reg <= ~wr_bank_reg;
      end

      wen_reg     <= w_store;
      waddr_reg   <= addr_of(wr_bank_reg, wdx, wdy);
      wdata_reg   <= bus.wr_pixel;

      rvalid1_reg <= bus.rd_valid;
      rin1_reg    <= r_in;
      raddr_reg   <= addr_of(rd_bank_eff, rdx, rdy);

      rd_done_reg <= rvalid1_reg;
      if (rvalid1_reg) rsel_reg <= rin1_reg ? SEL_RAM : SEL_BG;
    end
  end

  // Read-before-write on the same edge: a colliding read returns the previous contents.
  always_ff @(posedge clk) begin
    if (wen_reg) mem[waddr_reg] <= wdata_reg;
    if (rvalid1_reg && rin1_reg) ram_q_reg <= mem[raddr_reg];
  end

  always_comb begin
    rd_pixel_next = '0;
    case (rsel_reg)
      SEL_BG:  rd_pixel_next = BG_PIXEL;
      SEL_RAM: rd_pixel_next = ram_q_reg;
      default: rd_pixel_next = '0;
    endcase
  end

  assign bus.rd_pixel    = rd_pixel_next;
  assign bus.rd_done     = rd_done_reg;
  assign bus.wr_bank     = wr_bank_reg;
  assign bus.rd_bank     = rd_bank_reg;
  assign bus.frame_ready = frame_ready_reg;
  assign bus.drop_count  = drop_count_reg;
endmodule

// File: tb/tb_framebuf_window.sv
// Drives a double-buffered and a single-bank framebuf_window with the same stimulus and
// checks both against a frame-level model (linear positions, per-bank pixel arrays).
module tb_framebuf_window;
  localparam int SW = 8, SH = 4, X0 = 2, Y0 = 1, WW = 4, WH = 2, PW = 36;
  localparam int NPIX = SW * SH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wv = 1'b0, ws = 1'b0, rv = 1'b0, rs = 1'b0;
  logic [PW-1:0] wpix = '0;

  framebuf_window_if #(.PIXEL_W(PW)) bus_d ();
  framebuf_window_if #(.PIXEL_W(PW)) bus_s ();

  assign bus_d.wr_valid = wv;  assign bus_s.wr_valid = wv;
  assign bus_d.wr_sof   = ws;  assign bus_s.wr_sof   = ws;
  assign bus_d.wr_pixel = wpix; assign bus_s.wr_pixel = wpix;
  assign bus_d.rd_valid = rv;  assign bus_s.rd_valid = rv;
  assign bus_d.rd_sof   = rs;  assign bus_s.rd_sof   = rs;

  framebuf_window #(.SRC_W(SW), .SRC_H(SH), .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(WW), .WIN_H(WH),
                    .PIXEL_W(PW), .BG_PIXEL(36'h0), .DOUBLE_BUF(1))
    dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d.slave));
  framebuf_window #(.SRC_W(SW), .SRC_H(SH), .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(WW), .WIN_H(WH),
                    .PIXEL_W(PW), .BG_PIXEL(36'h0), .DOUBLE_BUF(0))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));

  typedef struct { int due; logic [PW-1:0] pix; } exp_t;

  // Model state, index 0 = double-buffered DUT, 1 = single-bank DUT.
  logic [PW-1:0] mmem [2][2][WW*WH];
  int  wp [2], rp [2], drop [2];
  bit  hold [2], fr [2], wb [2], rb [2];
  exp_t qd [$], qs [$];
  int  cyc = 0, n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      wp[d] = 0; rp[d] = 0; drop[d] = 0;
      hold[d] = 1'b0; fr[d] = 1'b0; wb[d] = 1'b0; rb[d] = (d == 0);
    end
    qd.delete();
    qs.delete();
  endtask

  function automatic bit in_win(input int pos);
    int x, y;
    x = pos % SW; y = pos / SW;
    return (x >= X0) && (x < X0 + WW) && (y >= Y0) && (y < Y0 + WH);
  endfunction

  function automatic int widx(input int pos);
    return (pos / SW - Y0) * WW + (pos % SW - X0);
  endfunction

  // Applies the inputs currently driven, as they will be sampled by the coming edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit   db, swap, writing, complete;
      int   pos;
      exp_t e;
      db   = (d == 0);
      swap = db && rs && fr[d];
      pos  = rs ? 0 : rp[d];
      if (rv) begin
        e.due = cyc + 2;
        e.pix = in_win(pos) ? mmem[d][swap ? wb[d] : rb[d]][widx(pos)] : '0;
        if (d == 0) qd.push_back(e); else qs.push_back(e);
        pos = (pos + 1) % NPIX;
      end
      rp[d] = pos;
      pos = ws ? 0 : wp[d];
      writing  = !hold[d] || (ws && !fr[d]);
      complete = 1'b0;
      if (wv) begin
        if (writing && in_win(pos)) mmem[d][wb[d]][widx(pos)] = wpix;
        complete = db && writing && (pos == NPIX - 1);
        pos = (pos + 1) % NPIX;
      end
      wp[d] = pos;
      if (db && hold[d] && ws && fr[d] && drop[d] < 255) drop[d]++;
      if (db) begin
        if (complete) hold[d] = 1'b1; else if (writing) hold[d] = 1'b0;
      end
      if (swap) begin rb[d] = wb[d]; wb[d] = !wb[d]; end
      if (complete) fr[d] = 1'b1; else if (swap) fr[d] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic          done, frv, wbk, rbk;
      logic [PW-1:0] pix;
      logic [7:0]    dc;
      bit            exp_done;
      exp_t          e;
      string         nm;
      nm = (d == 0) ? "dbl" : "sgl";
      if (d == 0) begin
        done = bus_d.rd_done; pix = bus_d.rd_pixel; frv = bus_d.frame_ready;
        wbk = bus_d.wr_bank; rbk = bus_d.rd_bank; dc = bus_d.drop_count;
        exp_done = (qd.size() > 0) && (qd[0].due == cyc);
        if (exp_done) e = qd.pop_front();
      end else begin
        done = bus_s.rd_done; pix = bus_s.rd_pixel; frv = bus_s.frame_ready;
        wbk = bus_s.wr_bank; rbk = bus_s.rd_bank; dc = bus_s.drop_count;
        exp_done = (qs.size() > 0) && (qs[0].due == cyc);
        if (exp_done) e = qs.pop_front();
      end
      chk({nm, ".rd_done"}, PW'(done), PW'(exp_done));
      if (exp_done) chk({nm, ".rd_pixel"}, pix, e.pix);
      chk({nm, ".frame_ready"}, PW'(frv), PW'(fr[d]));
      chk({nm, ".wr_bank"}, PW'(wbk), PW'(wb[d]));
      chk({nm, ".rd_bank"}, PW'(rbk), PW'(rb[d]));
      chk({nm, ".drop_count"}, PW'(dc), PW'(drop[d]));
    end
  endtask

  task automatic reset_checks(input string when);
    chk({when, ".dbl.rd_done"}, PW'(bus_d.rd_done), '0);
    chk({when, ".dbl.rd_pixel"}, bus_d.rd_pixel, '0);
    chk({when, ".dbl.frame_ready"}, PW'(bus_d.frame_ready), '0);
    chk({when, ".dbl.drop_count"}, PW'(bus_d.drop_count), '0);
    chk({when, ".dbl.wr_bank"}, PW'(bus_d.wr_bank), '0);
    chk({when, ".dbl.rd_bank"}, PW'(bus_d.rd_bank), PW'(1));
    chk({when, ".sgl.rd_done"}, PW'(bus_s.rd_done), '0);
    chk({when, ".sgl.rd_pixel"}, bus_s.rd_pixel, '0);
    chk({when, ".sgl.rd_bank"}, PW'(bus_s.rd_bank), '0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic idle();
    wv = 1'b0; ws = 1'b0; rv = 1'b0; rs = 1'b0;
  endtask

  task automatic write_frame(input string name, input int npix, input bit rs_last,
                             input int rd_pct);
    for (int i = 0; i < npix; i++) begin
      wv   = 1'b1;
      ws   = (i == 0);
      wpix = PW'({$urandom(), $urandom()});
      rv   = ($urandom_range(99, 0) < rd_pct);
      rs   = rs_last && (i == npix - 1);
      tick();
      if ($urandom_range(3, 0) == 0) begin
        idle();
        tick();
      end
    end
    idle();
    $display("write %s: %0d pixels, dbl frame_ready=%0b drop=%0d wr_bank=%0b",
             name, npix, fr[0], drop[0], wb[0]);
  endtask

  task automatic read_frame(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      rv = 1'b1;
      rs = (i == 0);
      tick();
    end
    idle();
    repeat (3) tick();
    $display("read %s: %0d pixels, dbl rd_bank=%0b wr_bank=%0b, compared so far %0d",
             name, n, rb[0], wb[0], n_cmp);
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < WW * WH; k++) mmem[d][b][k] = '0;
    model_reset();
    idle();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    rst_n = 1'b1;
    $display("reset released");

    write_frame("A", NPIX, 1'b0, 0);
    read_frame("A+wrap", 40);
    write_frame("B", NPIX, 1'b0, 30);
    write_frame("dropped", NPIX, 1'b0, 30);
    for (int i = 0; i < 260; i++) begin
      idle();
      ws = 1'b1;
      tick();
    end
    idle();
    $display("sof burst: dbl drop_count model=%0d", drop[0]);
    read_frame("B", NPIX);
    write_frame("partial", 10, 1'b0, 30);
    write_frame("C", NPIX, 1'b1, 30);
    repeat (2) tick();
    read_frame("C", NPIX);

    for (int i = 0; i < 400; i++) begin
      wv   = $urandom_range(1, 0) == 1;
      ws   = $urandom_range(39, 0) == 0;
      rv   = $urandom_range(9, 0) < 6;
      rs   = $urandom_range(39, 0) == 0;
      wpix = PW'({$urandom(), $urandom()});
      tick();
    end
    idle();
    $display("random phase done: dbl frame_ready=%0b drop=%0d", fr[0], drop[0]);

    rv = 1'b1; rs = 1'b1;
    tick();
    rs = 1'b0;
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    $display("mid-read reset applied");
    write_frame("E", NPIX, 1'b0, 0);
    read_frame("E", NPIX);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
